// File: rtl/hv_bundle_if.sv
// Handshake bundle for hv_bundle_accumulator.
// Carries the input term stream, the bundled result and the busy status.
interface hv_bundle_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 4
);
    logic [COUNT_W-1:0] num_terms;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_sum;
    logic               out_overflow;
    logic               busy;

    modport master (
        output num_terms, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_overflow, busy
    );

    modport slave (
        input  num_terms, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_overflow, busy
    );
endinterface

// File: rtl/hv_bundle_accumulator.sv
// Sums a programmable number of adder-stage terms and presents one bundled result.
// Define ACCUM_SATURATE_EN to clamp the sum at all ones instead of wrapping.
//
// state | meaning
// IDLE  | waiting for the first term of a bundle
// ACCUM | adding the remaining terms
// DONE  | result offered on the output handshake, input stalled
module hv_bundle_accumulator #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    hv_bundle_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   res_sum_q, res_sum_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] n_lat_q, n_lat_d;
    logic               ovf_q, ovf_d;
    logic               res_ovf_q, res_ovf_d;

    logic               in_ready_w;
    logic               accept;
    logic [WIDTH:0]     sum_ext;
    logic [COUNT_W-1:0] n_new;
    logic [COUNT_W-1:0] cnt_inc;

    assign in_ready_w = (state_q != DONE);
    assign accept     = bus.in_valid && in_ready_w;
    assign sum_ext    = {1'b0, acc_q} + {1'b0, bus.in_data};
    assign n_new      = (bus.num_terms == '0) ? COUNT_W'(1) : bus.num_terms;
    assign cnt_inc    = cnt_q + COUNT_W'(1);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        n_lat_d   = n_lat_q;
        ovf_d     = ovf_q;
        res_sum_d = res_sum_q;
        res_ovf_d = res_ovf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = bus.in_data;
                    cnt_d   = COUNT_W'(1);
                    ovf_d   = 1'b0;
                    n_lat_d = n_new;
                    state_d = (n_new == COUNT_W'(1)) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    ovf_d = ovf_q | sum_ext[WIDTH];
`ifdef ACCUM_SATURATE_EN
                    // All ones plus any term either carries again or stays put,
                    // so the clamp persists for the rest of the bundle.
                    acc_d = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
`else
                    acc_d = sum_ext[WIDTH-1:0];
`endif
                    cnt_d = cnt_inc;
                    if (cnt_inc == n_lat_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Result registers only move when a bundle completes, so the last
        // result stays visible through the following IDLE and ACCUM phases.
        if ((state_d == DONE) && (state_q != DONE)) begin
            res_sum_d = acc_d;
            res_ovf_d = ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            n_lat_q   <= '0;
            ovf_q     <= 1'b0;
            res_sum_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            n_lat_q   <= n_lat_d;
            ovf_q     <= ovf_d;
            res_sum_q <= res_sum_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign bus.in_ready     = in_ready_w;
    assign bus.out_valid    = (state_q == DONE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.out_sum      = res_sum_q;
    assign bus.out_overflow = res_ovf_q;
endmodule

// File: tb/tb_hv_bundle_accumulator.sv
// Self-checking bench for hv_bundle_accumulator: directed table, corner sequences,
// and randomized bundles checked against an arithmetic reference model.
module tb_hv_bundle_accumulator;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hv_bundle_if #(.WIDTH(W), .COUNT_W(CW)) bus ();

    hv_bundle_accumulator #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        int nt;
        int n;
        int t[4];
        int stall;
        int exp_sum;
        int exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Unbounded sum of non-negative terms: a carry happened iff it reached 2**W.
    function automatic void model(input int terms[$], output int s, output int o);
        int tot;
        tot = 0;
        foreach (terms[i]) tot += terms[i];
        o = (tot >= (1 << W)) ? 1 : 0;
`ifdef ACCUM_SATURATE_EN
        s = o ? ((1 << W) - 1) : tot;
`else
        s = tot % (1 << W);
`endif
    endfunction

    // Entered and left at a negedge with the DUT idle.
    task automatic run_bundle(input string nm, input int nt, input int terms[$],
                              input int gap_max, input int stall,
                              input int exp_sum, input int exp_ovf);
        int nl;
        int g;
        nl = (nt == 0) ? 1 : nt;
        bus.out_ready = 1'b0;
        for (int i = 0; i < nl; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                bus.in_valid = 1'b0;
                bus.in_data  = W'($urandom);
                @(negedge clk);
            end
            bus.in_valid  = 1'b1;
            bus.in_data   = W'(terms[i]);
            bus.num_terms = (i == 0) ? CW'(nt) : CW'($urandom);
            if (i == nl - 1) begin
                chk({nm, " in_ready before last"}, bus.in_ready, 1);
                chk({nm, " out_valid before last"}, bus.out_valid, 0);
            end
            @(negedge clk);
        end
        // junk on the input while the result is pending must not be consumed
        bus.in_valid = 1'b1;
        bus.in_data  = W'($urandom);
        chk({nm, " out_valid latency"}, bus.out_valid, 1);
        chk({nm, " out_sum"}, bus.out_sum, exp_sum);
        chk({nm, " out_overflow"}, bus.out_overflow, exp_ovf);
        for (int k = 0; k < stall; k++) begin
            chk({nm, " stall in_ready"}, bus.in_ready, 0);
            chk({nm, " stall out_valid"}, bus.out_valid, 1);
            chk({nm, " stall out_sum"}, bus.out_sum, exp_sum);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        chk({nm, " handshake busy"}, bus.busy, 1);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk({nm, " out_valid drop"}, bus.out_valid, 0);
        chk({nm, " busy drop"}, bus.busy, 0);
        chk({nm, " out_sum hold"}, bus.out_sum, exp_sum);
    endtask

    initial begin
        int q[$];
        int es, eo;
        int nt;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.num_terms = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{3, 3, '{10, 20, 30, 0}, 0, 60, 0};
`ifdef ACCUM_SATURATE_EN
        vecs[1] = '{2, 2, '{200, 100, 0, 0}, 0, 255, 1};
        vecs[5] = '{4, 2, '{255, 1, 0, 0}, 0, 255, 1};
        vecs[6] = '{3, 3, '{250, 10, 5, 0}, 0, 255, 1};
`else
        vecs[1] = '{2, 2, '{200, 100, 0, 0}, 0, 44, 1};
        vecs[5] = '{4, 2, '{255, 1, 0, 0}, 0, 0, 1};
        vecs[6] = '{3, 3, '{250, 10, 5, 0}, 0, 9, 1};
`endif
        vecs[2] = '{0, 1, '{77, 0, 0, 0}, 0, 77, 0};
        vecs[3] = '{1, 1, '{77, 0, 0, 0}, 0, 77, 0};
        vecs[4] = '{2, 2, '{5, 6, 0, 0}, 4, 11, 0};
        vecs[7] = '{4, 4, '{0, 0, 0, 0}, 1, 0, 0};
        // row 5 uses num_terms=4 but only two listed terms; fix up to four
        vecs[5].t = '{255, 1, 0, 0};
        vecs[5].n = 4;

        // Reset state with rst_n held low
        repeat (2) @(negedge clk);
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset out_sum", bus.out_sum, 0);
        chk("reset out_overflow", bus.out_overflow, 0);
        chk("reset busy", bus.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[v]) begin
            q.delete();
            for (int i = 0; i < vecs[v].n; i++) q.push_back(vecs[v].t[i]);
            run_bundle($sformatf("vec%0d", v), vecs[v].nt, q, 0, vecs[v].stall,
                       vecs[v].exp_sum, vecs[v].exp_ovf);
        end

        // Leave a nonzero result so the abort reset visibly clears it
        q = '{9, 8};
        run_bundle("pre_abort", 2, q, 0, 0, 17, 0);

        // Abort: two of four beats, then an asynchronous reset mid-cycle
        bus.num_terms = CW'(4);
        bus.in_valid  = 1'b1;
        bus.in_data   = W'(50);
        @(negedge clk);
        bus.in_data   = W'(60);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        chk("abort busy before", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", bus.busy, 0);
        chk("abort out_valid", bus.out_valid, 0);
        chk("abort out_sum", bus.out_sum, 0);
        chk("abort in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q = '{1, 1, 1, 1};
        run_bundle("after_abort", 4, q, 0, 0, 4, 0);

        // Randomized bundles with input gaps and output stalls
        for (int r = 0; r < 40; r++) begin
            nt = int'($urandom_range(15, 0));
            q.delete();
            for (int i = 0; i < ((nt == 0) ? 1 : nt); i++)
                q.push_back(($urandom_range(1, 0) == 1) ? int'($urandom_range(255, 200))
                                                         : int'($urandom_range(40, 0)));
            model(q, es, eo);
            run_bundle($sformatf("rand%0d", r), nt, q, 2, int'($urandom_range(3, 0)), es, eo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
